gpio_bus_mux: RTL
=================

Name: gpio_bus_mux

Overview:
Time-multiplexes the CPU core's address and data buses onto one narrow, shared, bidirectional GPIO byte lane. The address is sent MSB-first over several phases, then a data phase follows, each phase marked by a strobe. Pin-side interrupt inputs are synchronised and conditioned for the core. Sits between the 8227 core and the breakout-pin wrapper, replacing direct bus-to-pin wiring.

Parameters:
DATA_W, 8, width of shared pin lane and of the data word.
ADDR_W, 16, CPU address width; must be an integer multiple of DATA_W; NPH = ADDR_W/DATA_W address phases.
HOLD, 1, clock cycles each phase is held (>=1).
SYNC_STAGES, 2, synchroniser depth for interrupt pins (>=2).

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
cs  in  1  chip select, active low; high forces idle/abort
bus_req  in  1  core requests a transfer; sampled only in IDLE
bus_rw  in  1  1 = read, 0 = write
bus_addr  in  ADDR_W  transfer address
bus_wdata  in  DATA_W  write data
bus_rdata  out  DATA_W  read data, valid from bus_done until next read completes
bus_busy  out  1  high from the cycle after acceptance through the DONE cycle
bus_done  out  1  one-cycle completion pulse
bus_abort  out  1  one-cycle pulse when a transfer is killed by cs
pin_out  out  DATA_W  value driven onto the lane
pin_oe  out  1  lane output enable
pin_in  in  DATA_W  lane input value
addr_stb  out  NPH  one-hot address-phase strobe; bit NPH-1 = most significant slice
wr_n  out  1  write strobe, active low
rd_n  out  1  read strobe, active low
irq_n_pin  in  1  async IRQ pin, active low
nmi_n_pin  in  1  async NMI pin, active low
irq  out  1  synchronised IRQ level, active high
nmi  out  1  one-cycle pulse per NMI falling edge

Behaviour:
- Reset values: pin_out=0, pin_oe=0, addr_stb=0, wr_n=1, rd_n=1, bus_rdata=0, bus_busy=0, bus_done=0, bus_abort=0, irq=0, nmi=0. Synchroniser flops reset to 1.
- Registered outputs only; no combinational path from inputs to pins.
- States: IDLE, ADDR, TURN, DATA, DONE. A phase counter counts 0..HOLD-1 and an index counts NPH-1 down to 0.
- IDLE: if bus_req=1 and cs=0 at a clock edge, latch addr, wdata and rw, then enter ADDR with idx=NPH-1. Call this edge cycle 0.
- ADDR: pin_oe=1; pin_out=bus_addr[idx*DATA_W +: DATA_W]; addr_stb=1<<idx. Each slice is held for HOLD cycles, then idx decrements. After idx 0 completes, a write goes to DATA and a read goes to TURN.
- TURN (reads only): exactly 1 cycle with pin_oe=0, all strobes inactive. Bus-contention gap.
- DATA write: pin_oe=1, pin_out=wdata, wr_n=0 for HOLD cycles.
- DATA read: pin_oe=0, rd_n=0 for HOLD cycles. pin_in is captured into bus_rdata on the last cycle of the phase.
- DONE: 1 cycle. bus_done=1, strobes inactive, pin_oe=0, then IDLE. bus_req is ignored in DONE, so back-to-back transfers have a minimum of 1 IDLE cycle between them.
- Latency from the cycle-0 edge to bus_done high: write = (NPH+1)*HOLD+1 cycles; read = (NPH+1)*HOLD+2 cycles.
- pin_out holds its last value when pin_oe=0.
- cs=1 in any non-IDLE state: next cycle IDLE, pin_oe=0, strobes inactive, bus_abort=1 for one cycle, no bus_done, bus_rdata unchanged.
- cs=1 in IDLE: requests are not accepted; no abort pulse.
- Reset mid-transfer: immediate return to reset values; no done or abort pulse.
- irq = NOT of the final synchroniser stage of irq_n_pin. Latency is SYNC_STAGES cycles.
- nmi pulses 1 cycle when the synchronised nmi_n goes 1->0. A held-low pin produces no further pulses. nmi is independent of cs and of the transfer state.

Test Plan:
- Write (HOLD=1, NPH=2, cs=0), addr=0xBEEF, wdata=0x5A:
  - cycle 1: pin_out=0xBE, addr_stb=2'b10, pin_oe=1.
  - cycle 2: pin_out=0xEF, addr_stb=2'b01.
  - cycle 3: pin_out=0x5A, wr_n=0.
  - cycle 4: bus_done=1.
- Read, addr=0x1234, pin_in=0xA7:
  - cycles 1-2: address 0x12 then 0x34.
  - cycle 3: pin_oe=0, no strobes.
  - cycle 4: rd_n=0.
  - cycle 5: bus_done=1, bus_rdata=0xA7, and 0xA7 is held through the next write.
- HOLD=3 write of 0x00FF/0x11: each address slice is held 3 cycles, wr_n is low 3 cycles, and bus_done arrives at cycle 10. Also check a parameter set DATA_W=4, ADDR_W=16 (NPH=4) walks addr_stb 1000->0100->0010->0001.
- Raise cs during slice 2 of a read: next cycle IDLE, bus_abort=1, pin_oe=0, no bus_done, bus_rdata unchanged. A bus_req with cs=1 is never accepted.
- Pull nmi_n_pin low and hold it for 20 cycles: exactly one nmi pulse, 2-3 cycles after the edge. irq_n_pin=0 gives irq=1 within SYNC_STAGES+1 cycles. Assert nrst mid-write: all outputs return to reset values immediately.

Source files
------------

// File: rtl/gpio_bus_mux.sv
// Multiplexes the CPU address and data buses onto one shared GPIO byte lane.
// Also synchronises the pin-side IRQ and NMI inputs for the core.
module gpio_bus_mux #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 16,
   parameter int HOLD        = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        cs,
   input  logic                        bus_req,
   input  logic                        bus_rw,
   input  logic [ADDR_W-1:0]           bus_addr,
   input  logic [DATA_W-1:0]           bus_wdata,
   output logic [DATA_W-1:0]           bus_rdata,
   output logic                        bus_busy,
   output logic                        bus_done,
   output logic                        bus_abort,
   output logic [DATA_W-1:0]           pin_out,
   output logic                        pin_oe,
   input  logic [DATA_W-1:0]           pin_in,
   output logic [ADDR_W/DATA_W-1:0]    addr_stb,
   output logic                        wr_n,
   output logic                        rd_n,
   input  logic                        irq_n_pin,
   input  logic                        nmi_n_pin,
   output logic                        irq,
   output logic                        nmi
);

   localparam int NPH  = ADDR_W / DATA_W;
   localparam int IDXW = (NPH > 1) ? $clog2(NPH) : 1;
   localparam int CNTW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NPH - 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_TURN = 3'd2,
      S_DATA = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                 state_r;
   logic [IDXW-1:0]        idx_r;
   logic [CNTW-1:0]        cnt_r;
   logic [ADDR_W-1:0]      addr_r;
   logic [DATA_W-1:0]      wdata_r;
   logic                   rw_r;
   logic                   rd_cap_r;
   logic [DATA_W-1:0]      slice_s;
   logic [NPH-1:0]         stb_s;
   logic [SYNC_STAGES-2:0] irq_sync_r;
   logic [SYNC_STAGES-1:0] nmi_sync_r;
   logic                   nmi_prev_r;

   // Current address slice and its one-hot strobe, selected by the phase index.
   always_comb begin
      slice_s        = addr_r[int'(idx_r)*DATA_W +: DATA_W];
      stb_s          = '0;
      stb_s[idx_r]   = 1'b1;
   end

   // Transfer sequencer; pin outputs are registered from the state of the previous cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r   <= S_IDLE;
         idx_r     <= '0;
         cnt_r     <= '0;
         addr_r    <= '0;
         wdata_r   <= '0;
         rw_r      <= 1'b0;
         rd_cap_r  <= 1'b0;
         pin_out   <= '0;
         pin_oe    <= 1'b0;
         addr_stb  <= '0;
         wr_n      <= 1'b1;
         rd_n      <= 1'b1;
         bus_rdata <= '0;
         bus_busy  <= 1'b0;
         bus_done  <= 1'b0;
         bus_abort <= 1'b0;
      end else if (cs && (state_r != S_IDLE)) begin
         state_r   <= S_IDLE;
         cnt_r     <= '0;
         rd_cap_r  <= 1'b0;
         pin_oe    <= 1'b0;
         addr_stb  <= '0;
         wr_n      <= 1'b1;
         rd_n      <= 1'b1;
         bus_busy  <= 1'b0;
         bus_done  <= 1'b0;
         bus_abort <= 1'b1;
      end else begin
         bus_done  <= 1'b0;
         bus_abort <= 1'b0;
         rd_cap_r  <= 1'b0;
         pin_oe    <= 1'b0;
         addr_stb  <= '0;
         wr_n      <= 1'b1;
         rd_n      <= 1'b1;
         bus_busy  <= (state_r != S_IDLE);
         if (rd_cap_r) begin
            bus_rdata <= pin_in;
         end
         case (state_r)
            S_IDLE: begin
               if (bus_req && !cs) begin
                  addr_r  <= bus_addr;
                  wdata_r <= bus_wdata;
                  rw_r    <= bus_rw;
                  idx_r   <= IDX_TOP;
                  cnt_r   <= '0;
                  state_r <= S_ADDR;
               end
            end
            S_ADDR: begin
               pin_oe   <= 1'b1;
               pin_out  <= slice_s;
               addr_stb <= stb_s;
               if (cnt_r == CNT_LAST) begin
                  cnt_r <= '0;
                  if (idx_r == '0) begin
                     state_r <= rw_r ? S_TURN : S_DATA;
                  end else begin
                     idx_r <= idx_r - IDXW'(1);
                  end
               end else begin
                  cnt_r <= cnt_r + CNTW'(1);
               end
            end
            S_TURN: begin
               cnt_r   <= '0;
               state_r <= S_DATA;
            end
            S_DATA: begin
               if (rw_r) begin
                  rd_n     <= 1'b0;
                  rd_cap_r <= (cnt_r == CNT_LAST);
               end else begin
                  pin_oe  <= 1'b1;
                  pin_out <= wdata_r;
                  wr_n    <= 1'b0;
               end
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= '0;
                  state_r <= S_DONE;
               end else begin
                  cnt_r <= cnt_r + CNTW'(1);
               end
            end
            S_DONE: begin
               bus_done <= 1'b1;
               state_r  <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // IRQ synchroniser; the inverted final stage is the irq flop itself.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         irq_sync_r <= '1;
         irq        <= 1'b0;
      end else begin
         irq_sync_r <= (SYNC_STAGES-1)'({irq_sync_r, irq_n_pin});
         irq        <= ~irq_sync_r[SYNC_STAGES-2];
      end
   end

   // NMI synchroniser with falling-edge detect on the synchronised level.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         nmi_sync_r <= '1;
         nmi_prev_r <= 1'b1;
         nmi        <= 1'b0;
      end else begin
         nmi_sync_r <= SYNC_STAGES'({nmi_sync_r, nmi_n_pin});
         nmi_prev_r <= nmi_sync_r[SYNC_STAGES-1];
         nmi        <= nmi_prev_r & ~nmi_sync_r[SYNC_STAGES-1];
      end
   end

endmodule
